// File: rtl/reg_share_pkg.sv
// Shared types and elaboration helpers for the shared-register arbiter.
// Both the FSM encoding and the hold-counter width are sourced from here.
package reg_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request at or after i_ptr,
// found by rotating the request vector, priority-encoding it, then un-rotating.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic                 o_found,
  output logic [$clog2(N)-1:0] o_idx
);

  localparam int PW = $clog2(N);
  localparam logic [PW:0] L_N = (PW+1)'(N);

  logic [N-1:0]  w_rot;
  logic [PW-1:0] w_off;
  logic [PW:0]   w_sum;

  // w_rot[j] = i_req[(j + i_ptr) mod N]; the left shift by N when i_ptr=0 yields zero.
  assign w_rot = (i_req >> i_ptr) | (i_req << (N - int'(i_ptr)));

  always_comb begin
    o_found = 1'b0;
    w_off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_found = 1'b1;
        w_off   = PW'(k);
      end
    end
  end

  assign w_sum = {1'b0, w_off} + {1'b0, i_ptr};
  assign o_idx = (w_sum >= L_N) ? PW'(w_sum - L_N) : w_sum[PW-1:0];

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter and load controller owning a shared WIDTH-bit register;
// one winner is loaded per arbitration, then the register is held HOLD_CYCLES cycles.
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int N           = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic [N-1:0]         i_req,
  input  logic [N*WIDTH-1:0]   i_din,
  output logic [N-1:0]         o_gnt,
  output logic [WIDTH-1:0]     o_q,
  output logic [$clog2(N)-1:0] o_owner,
  output logic                 o_valid,
  output logic                 o_busy
);

  localparam int PW = $clog2(N);
  localparam int CW = clog2_min1(HOLD_CYCLES);
  localparam logic [CW-1:0] L_HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [PW:0]   L_N         = (PW+1)'(N);

  state_t           r_state;
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [PW-1:0]    r_owner;
  logic             r_valid;
  logic [N-1:0]     r_gnt;
  logic             r_busy;

  logic             w_found;
  logic [PW-1:0]    w_win;
  logic [PW:0]      w_win_inc;
  logic [PW-1:0]    w_ptr_next;
  logic [WIDTH-1:0] w_slice [N];
  logic [N-1:0]     w_onehot;

  rr_pick #(.N(N)) u_pick (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_win)
  );

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign w_slice[gi]  = i_din[gi*WIDTH +: WIDTH];
    assign w_onehot[gi] = (w_win == PW'(gi));
  end

  assign w_win_inc  = {1'b0, w_win} + (PW+1)'(1);
  assign w_ptr_next = (w_win_inc == L_N) ? '0 : w_win_inc[PW-1:0];

  // CLR outranks everything but reset and deliberately leaves r_ptr/r_owner alone.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_owner <= '0;
      r_valid <= 1'b0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
    end else if (i_clr) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_q     <= '0;
      r_valid <= 1'b0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_q     <= w_slice[w_win];
            r_owner <= w_win;
            r_valid <= 1'b1;
            r_ptr   <= w_ptr_next;
            r_cnt   <= L_HOLD_LOAD;
            r_gnt   <= w_onehot;
            r_busy  <= 1'b1;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          r_gnt <= '0;
          if (HOLD_CYCLES > 1) begin
            r_state <= ST_HOLD;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_HOLD: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_gnt   = r_gnt;
  assign o_q     = r_q;
  assign o_owner = r_owner;
  assign o_valid = r_valid;
  assign o_busy  = r_busy;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench for reg_share_arbiter: a timing-level reference model predicts
// each grant, a negedge monitor compares every grant and the register outputs.
module tb_reg_share_arbiter;

  localparam int N           = 4;
  localparam int WIDTH       = 8;
  localparam int HOLD_CYCLES = 2;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clr   = 1'b0;
  logic [N-1:0]         req   = '0;
  logic [N*WIDTH-1:0]   din   = '0;
  logic [N-1:0]         gnt;
  logic [WIDTH-1:0]     q;
  logic [$clog2(N)-1:0] owner;
  logic                 valid;
  logic                 busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int               who;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   glog_who[$];
  int   glog_edge[$];

  reg_share_arbiter #(.N(N), .WIDTH(WIDTH), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clr   (clr),
    .i_req   (req),
    .i_din   (din),
    .o_gnt   (gnt),
    .o_q     (q),
    .o_owner (owner),
    .o_valid (valid),
    .o_busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: arbitration is allowed on any edge after the one that
  // re-enters idle; a load keeps the block busy for HOLD_CYCLES cycles.
  int               edge_n      = 0;
  int               m_ptr       = 0;
  int               m_idle_edge = 0;
  int               m_owner     = 0;
  int               m_win       = 0;
  logic [WIDTH-1:0] m_q         = '0;
  logic             m_valid     = 1'b0;
  logic             m_busy      = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr       = 0;
      m_idle_edge = edge_n;
      m_q         = '0;
      m_owner     = 0;
      m_valid     = 1'b0;
      m_busy      = 1'b0;
      exp_q.delete();
    end else begin
      edge_n++;
      if (clr) begin
        m_q         = '0;
        m_valid     = 1'b0;
        m_idle_edge = edge_n;
      end else if (edge_n > m_idle_edge && req != '0) begin
        m_win = -1;
        for (int k = 0; k < N; k++) begin
          if (m_win < 0 && req[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
        end
        m_q         = din[m_win*WIDTH +: WIDTH];
        m_owner     = m_win;
        m_valid     = 1'b1;
        m_ptr       = (m_win + 1) % N;
        m_idle_edge = edge_n + HOLD_CYCLES;
        exp_q.push_back('{who: m_win, data: m_q});
      end
      m_busy = (edge_n < m_idle_edge);
    end
  end

  // Monitor: pops one expectation per observed grant, and tracks register outputs every cycle.
  exp_t         mon_e;
  logic [N-1:0] mon_eg;
  int           mon_who;
  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt != '0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_grant: got gnt=%b expected none", gnt);
        end else begin
          mon_e  = exp_q.pop_front();
          mon_eg = '0;
          mon_eg[mon_e.who] = 1'b1;
          chk("grant_onehot", 32'(gnt), 32'(mon_eg));
          chk("grant_data", 32'(q), 32'(mon_e.data));
        end
        mon_who = -1;
        for (int k = 0; k < N; k++) if (gnt[k]) mon_who = k;
        glog_who.push_back(mon_who);
        glog_edge.push_back(edge_n);
      end else if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        n_checks++;
        n_errors++;
        $display("FAIL missing_grant: got gnt=0 expected requester %0d", mon_e.who);
      end
      chk("q", 32'(q), 32'(m_q));
      chk("owner", 32'(owner), 32'(m_owner));
      chk("valid", 32'(valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(m_busy));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Acts as the requesters: drops a bit when its grant is seen, optionally re-raises it next cycle.
  task automatic wait_grants(input int n, input bit reraise, input logic [N-1:0] mask);
    int           got;
    int           budget;
    logic [N-1:0] dropped;
    got     = 0;
    budget  = 100 * n;
    dropped = '0;
    while (got < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (reraise) req = req | dropped;
      dropped = '0;
      if (gnt != '0) begin
        got++;
        dropped = gnt & mask;
        req     = req & ~gnt;
      end
    end
    n_checks++;
    if (got < n) begin
      n_errors++;
      $display("FAIL grant_timeout: got %0d grants expected %0d", got, n);
    end
    req = '0;
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Single request from requester 2.
    din[2*WIDTH +: WIDTH] = 8'h3C;
    req = 4'b0100;
    wait_grants(1, 1'b0, 4'b0100);
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_q", 32'(q), 32'h3C);
    chk("single_valid", 32'(valid), 32'h1);
    chk("single_busy0", 32'(busy), 32'h1);
    for (int i = 1; i < HOLD_CYCLES; i++) begin
      tick();
      chk("single_busy_hold", 32'(busy), 32'h1);
    end
    tick();
    chk("single_busy_end", 32'(busy), 32'h0);

    // Asynchronous reset in the middle of a hold.
    din[1*WIDTH +: WIDTH] = 8'hA5;
    req = 4'b0010;
    wait_grants(1, 1'b0, 4'b0010);
    chk("pre_reset_q", 32'(q), 32'hA5);
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(gnt), 32'h0);
    chk("async_q", 32'(q), 32'h0);
    chk("async_owner", 32'(owner), 32'h0);
    chk("async_valid", 32'(valid), 32'h0);
    chk("async_busy", 32'(busy), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    req   = 4'b1000;
    wait_grants(1, 1'b0, 4'b1000);
    chk("post_reset_owner", 32'(owner), 32'h3);

    // Fairness with all requesters contending.
    tick();
    #1;
    glog_who.delete();
    glog_edge.delete();
    req = 4'b1111;
    wait_grants(5, 1'b1, 4'b1111);
    #1;
    chk("fair_count", 32'(glog_who.size()), 32'd5);
    for (int i = 0; i < glog_who.size() && i < 5; i++) begin
      chk("fair_order", 32'(glog_who[i]), 32'(i % N));
      if (i > 0) chk("fair_spacing", 32'(glog_edge[i] - glog_edge[i-1]), 32'(HOLD_CYCLES + 1));
    end

    // Pointer wrap: move PTR to 3, then contend with 0 and 1.
    tick();
    req = 4'b0100;
    wait_grants(1, 1'b0, 4'b0100);
    tick();
    #1;
    glog_who.delete();
    req = 4'b0011;
    wait_grants(2, 1'b1, 4'b0011);
    #1;
    chk("wrap_count", 32'(glog_who.size()), 32'd2);
    if (glog_who.size() >= 2) begin
      chk("wrap_first", 32'(glog_who[0]), 32'd0);
      chk("wrap_second", 32'(glog_who[1]), 32'd1);
    end

    // CLR and REQ on the same idle edge.
    repeat (4) tick();
    clr = 1'b1;
    req = 4'b0001;
    tick();
    chk("clr_tie_gnt", 32'(gnt), 32'h0);
    chk("clr_tie_q", 32'(q), 32'h0);
    chk("clr_tie_valid", 32'(valid), 32'h0);
    clr = 1'b0;
    glog_who.delete();
    wait_grants(1, 1'b0, 4'b0001);
    #1;
    chk("clr_tie_next", (glog_who.size() > 0) ? 32'(glog_who[0]) : 32'hFFFF_FFFF, 32'd0);

    // CLR during hold, with a pending request behind it.
    tick();
    din[1*WIDTH +: WIDTH] = 8'h5A;
    req = 4'b0010;
    wait_grants(1, 1'b0, 4'b0010);
    tick();
    clr = 1'b1;
    din[2*WIDTH +: WIDTH] = 8'hC3;
    req = 4'b0100;
    tick();
    chk("clr_hold_q", 32'(q), 32'h0);
    chk("clr_hold_owner", 32'(owner), 32'h1);
    chk("clr_hold_valid", 32'(valid), 32'h0);
    chk("clr_hold_busy", 32'(busy), 32'h0);
    clr = 1'b0;
    tick();
    chk("clr_hold_regrant", 32'(gnt), 32'h4);
    chk("clr_hold_regrant_q", 32'(q), 32'hC3);
    req = '0;

    // Randomised traffic with occasional clears.
    for (int c = 0; c < 1500; c++) begin
      tick();
      clr = ($urandom_range(0, 39) == 0);
      req = req & ~gnt;
      for (int i = 0; i < N; i++) begin
        if (!req[i] && !gnt[i] && $urandom_range(0, 3) == 0) begin
          din[i*WIDTH +: WIDTH] = WIDTH'($urandom);
          req[i] = 1'b1;
        end
      end
    end
    clr = 1'b0;
    req = '0;
    repeat (10) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
